// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster-order luma stream into vertical
// 3-pixel columns (rows r-2, r-1, r at column x) with column-aligned
// valid / start-of-line / end-of-line flags for the edge stage.
module line_buffer_3row #(
  parameter int Y_DEPTH = 8,
  parameter int H_SIZE  = 640
) (
  input  logic               i_pclk,
  input  logic               i_arstn,
  input  logic               i_sof,
  input  logic               i_valid,
  input  logic [Y_DEPTH-1:0] i_pixel,
  output logic [Y_DEPTH-1:0] o_pixel_11,
  output logic [Y_DEPTH-1:0] o_pixel_00,
  output logic [Y_DEPTH-1:0] o_pixel_01,
  output logic               o_valid,
  output logic               o_sol,
  output logic               o_eol
);

  localparam int             XW      = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(H_SIZE - 1);
  localparam logic [1:0]     LC_FULL = 2'd2;

  // Frame position: column and saturating line count.
  logic [XW-1:0] x_q, x_d, x_cur;
  logic [1:0]    lc_q, lc_d, lc_cur;
  logic          emit;

  // LB1 holds row r-1, LB2 holds row r-2.
  logic [Y_DEPTH-1:0] lb1_mem [0:H_SIZE-1];
  logic [Y_DEPTH-1:0] lb2_mem [0:H_SIZE-1];

  // LB2 is written one cycle after the read of LB1 so that both memories
  // keep a registered read port; the data is the LB1 word just captured.
  logic          lb2_we_q;
  logic [XW-1:0] lb2_wa_q;

  logic [Y_DEPTH-1:0] pix_top_q, pix_mid_q, pix_bot_q;
  logic               valid_q, sol_q, eol_q;

  // Effective position this cycle (start-of-frame forces column 0, line 0)
  // and the position after an accepted pixel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    x_cur  = i_sof ? '0 : x_q;
    lc_cur = i_sof ? 2'd0 : lc_q;
    x_d    = x_cur;
    lc_d   = lc_cur;
    if (i_valid) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        if (lc_cur != LC_FULL) lc_d = lc_cur + 2'd1;
      end else begin
        x_d = x_cur + 1'b1;
      end
    end
    emit = i_valid && (lc_cur == LC_FULL);
  end

  // Column / line counter registers.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!i_arstn) begin
      x_q  <= '0;
      lc_q <= 2'd0;
    end else begin
      x_q  <= x_d;
      lc_q <= lc_d;
    end
  end

  // Column output registers: pixels load on accepted pixels only, flags
  // are per-cycle and gated by the third-row condition.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      pix_top_q <= '0;
      pix_mid_q <= '0;
      pix_bot_q <= '0;
      valid_q   <= 1'b0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      lb2_we_q  <= 1'b0;
      lb2_wa_q  <= '0;
    end else begin
      if (i_valid) begin
        pix_bot_q <= i_pixel;
        pix_mid_q <= lb1_mem[x_cur];
        pix_top_q <= lb2_mem[x_cur];
      end
      valid_q  <= emit;
      sol_q    <= emit && (x_cur == '0);
      eol_q    <= emit && (x_cur == X_LAST);
      lb2_we_q <= i_valid;
      lb2_wa_q <= x_cur;
    end
  end

  // Line memory writes: current pixel into LB1, the displaced LB1 word into LB2.
  always_ff @(posedge i_pclk) begin
    // NOTE: the memories have no reset; stale contents are harmless because
    // output valid is held off until two fresh lines have been written.
    if (i_valid)  lb1_mem[x_cur]    <= i_pixel;
    if (lb2_we_q) lb2_mem[lb2_wa_q] <= pix_mid_q;
  end

  assign o_pixel_11 = pix_top_q;
  assign o_pixel_00 = pix_mid_q;
  assign o_pixel_01 = pix_bot_q;
  assign o_valid    = valid_q;
  assign o_sol      = sol_q;
  assign o_eol      = eol_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row: two instances (H_SIZE=4 and the
// minimum H_SIZE=2) share one stimulus stream; a frame-store model predicts
// each column triple, and per-instance monitors pop and compare.
module tb_line_buffer_3row;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sof = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] pix = 8'h00;

  logic [7:0] top_a, mid_a, bot_a, top_b, mid_b, bot_b;
  logic       val_a, sol_a, eol_a, val_b, sol_b, eol_b;

  line_buffer_3row #(.Y_DEPTH(8), .H_SIZE(4)) dut_a (
    .i_pclk(clk), .i_arstn(rst_n), .i_sof(sof), .i_valid(valid), .i_pixel(pix),
    .o_pixel_11(top_a), .o_pixel_00(mid_a), .o_pixel_01(bot_a),
    .o_valid(val_a), .o_sol(sol_a), .o_eol(eol_a));

  line_buffer_3row #(.Y_DEPTH(8), .H_SIZE(2)) dut_b (
    .i_pclk(clk), .i_arstn(rst_n), .i_sof(sof), .i_valid(valid), .i_pixel(pix),
    .o_pixel_11(top_b), .o_pixel_00(mid_b), .o_pixel_01(bot_b),
    .o_valid(val_b), .o_sol(sol_b), .o_eol(eol_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic       sol;
    logic       eol;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;

  // Frame model: every accepted pixel stored by (instance, row, col).
  logic [7:0] fr [int];
  int row_m [2];
  int col_m [2];
  int hsz   [2] = '{4, 2};

  // Last accepted pixel since reset: what the bottom output must hold in gaps.
  logic [7:0] hold_q;

  always @(posedge clk) cyc_cnt++;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) hold_q <= 8'h00;
    else if (valid) hold_q <= pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int key(input int k, input int r, input int c);
    return k * 1000000 + r * 100 + c;
  endfunction

  task automatic model(input int k, input bit s, input bit v, input logic [7:0] p);
    exp_t e;
    if (s) begin
      row_m[k] = 0;
      col_m[k] = 0;
    end
    if (v) begin
      fr[key(k, row_m[k], col_m[k])] = p;
      if (row_m[k] >= 2) begin
        e.top = fr[key(k, row_m[k] - 2, col_m[k])];
        e.mid = fr[key(k, row_m[k] - 1, col_m[k])];
        e.bot = p;
        e.sol = (col_m[k] == 0);
        e.eol = (col_m[k] == hsz[k] - 1);
        e.cyc = cyc_cnt + 1;
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
      col_m[k]++;
      if (col_m[k] == hsz[k]) begin
        col_m[k] = 0;
        row_m[k]++;
      end
    end
  endtask

  task automatic drive(input bit s, input bit v, input logic [7:0] p);
    @(negedge clk);
    sof   = s;
    valid = v;
    pix   = p;
    model(0, s, v, p);
    model(1, s, v, p);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_top"}, top_a, 0); check({tag, "_a_mid"}, mid_a, 0);
    check({tag, "_a_bot"}, bot_a, 0); check({tag, "_a_val"}, val_a, 0);
    check({tag, "_a_sol"}, sol_a, 0); check({tag, "_a_eol"}, eol_a, 0);
    check({tag, "_b_top"}, top_b, 0); check({tag, "_b_mid"}, mid_b, 0);
    check({tag, "_b_bot"}, bot_b, 0); check({tag, "_b_val"}, val_b, 0);
    check({tag, "_b_sol"}, sol_b, 0); check({tag, "_b_eol"}, eol_b, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sof   = 1'b0;
    valid = 1'b0;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      row_m[k] = 0;
      col_m[k] = 0;
    end
    #1 check_zero("rst_mid");
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
  endtask

  // Pattern pixel: value 16*row+col for linear index i on a 4-wide line.
  function automatic logic [7:0] pat(input int i);
    return 8'((i / 4) * 16 + (i % 4));
  endfunction

  // Monitor for the H_SIZE=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (val_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_valid: got valid with bottom 0x%0h, expected none", bot_a);
        end else begin
          e = q_a.pop_front();
          check("a_top", top_a, e.top);
          check("a_mid", mid_a, e.mid);
          check("a_bot", bot_a, e.bot);
          check("a_sol", sol_a, e.sol);
          check("a_eol", eol_a, e.eol);
          check("a_latency", cyc_cnt, e.cyc);
        end
      end else begin
        check("a_hold", bot_a, hold_q);
      end
    end
  end

  // Monitor for the H_SIZE=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (val_b) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_valid: got valid with bottom 0x%0h, expected none", bot_b);
        end else begin
          e = q_b.pop_front();
          check("b_top", top_b, e.top);
          check("b_mid", mid_b, e.mid);
          check("b_bot", bot_b, e.bot);
          check("b_sol", sol_b, e.sol);
          check("b_eol", eol_b, e.eol);
          check("b_latency", cyc_cnt, e.cyc);
        end
      end else begin
        check("b_hold", bot_b, hold_q);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      row_m[k] = 0;
      col_m[k] = 0;
    end
    #1 check_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Gap-free pattern frame, rows 0..5.
    drive(1, 1, pat(0));
    for (int i = 1; i < 24; i++) drive(0, 1, pat(i));

    // Same pattern with 1,0,0,1 valid through rows 2-3.
    drive(1, 1, pat(0));
    for (int i = 1; i < 24; i++) begin
      drive(0, 1, pat(i));
      if (i >= 8 && i < 16) begin
        drive(0, 0, 8'($urandom));
        drive(0, 0, 8'($urandom));
      end
    end

    // Start-of-frame landing at (3,2) restarts the frame with that pixel.
    drive(1, 1, pat(0));
    for (int i = 1; i < 14; i++) drive(0, 1, pat(i));
    drive(1, 1, pat(14));
    for (int j = 0; j < 14; j++) drive(0, 1, 8'(8'h80 + j));

    // Reset pulsed mid row 3, then resume without start-of-frame.
    drive(1, 1, pat(0));
    for (int i = 1; i < 14; i++) drive(0, 1, pat(i));
    do_reset();
    for (int j = 0; j < 20; j++) drive(0, 1, 8'($urandom));

    // Two back-to-back frames with disjoint value ranges and random gaps.
    drive(1, 1, 8'($urandom_range(0, 127)));
    for (int j = 1; j < 16; j++) drive(0, 1, 8'($urandom_range(0, 127)));
    drive(1, 1, 8'($urandom_range(128, 255)));
    for (int j = 1; j < 24; j++)
      drive(0, ($urandom_range(0, 3) != 0), 8'($urandom_range(128, 255)));

    // Long random run: sparse gaps and occasional start-of-frame.
    for (int j = 0; j < 1500; j++)
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), 8'($urandom));

    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    @(negedge clk);
    check("a_drain", q_a.size(), 0);
    check("b_drain", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
